// File: rtl/bram_access_scheduler_if.sv
// Client-side request/response bundle and dual-port BRAM bundle for the
// access scheduler. Port 1 of the RAM is read-only, port 2 is write-only.
interface bram_access_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    init_req;
    logic                    busy;
    logic                    rd_valid;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_ready;
    logic                    rd_data_valid;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    wr_valid;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic                    wr_ready;

    modport master (
        output init_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_strb,
        input  busy, rd_ready, rd_data_valid, rd_data, wr_ready
    );
    modport slave (
        input  init_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_strb,
        output busy, rd_ready, rd_data_valid, rd_data, wr_ready
    );
endinterface

interface bram_access_scheduler_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    ram_en;
    logic [ADDR_WIDTH-1:0]   ram_addr_1;
    logic [DATA_WIDTH/8-1:0] ram_write_en_1;
    logic [DATA_WIDTH-1:0]   ram_data_out_1;
    logic [ADDR_WIDTH-1:0]   ram_addr_2;
    logic [DATA_WIDTH/8-1:0] ram_write_en_2;
    logic [DATA_WIDTH-1:0]   ram_data_in_2;

    modport master (
        output ram_en, ram_addr_1, ram_write_en_1, ram_addr_2, ram_write_en_2, ram_data_in_2,
        input  ram_data_out_1
    );
    modport slave (
        input  ram_en, ram_addr_1, ram_write_en_1, ram_addr_2, ram_write_en_2, ram_data_in_2,
        output ram_data_out_1
    );
endinterface

// File: rtl/bram_access_scheduler.sv
// Arbitrates one read and one write port onto a dual-port BRAM, and clears the
// whole RAM after reset or on request. Writes win same-address collisions.
module bram_access_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    bram_access_scheduler_if.slave       s_req,
    bram_access_scheduler_ram_if.master  m_ram
);
    localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;
    logic                    r_rd_data_valid;

    logic                    w_collision;
    logic                    w_busy;
    logic                    w_rd_ready;
    logic                    w_wr_ready;
    logic [ADDR_WIDTH-1:0]   w_addr_2;
    logic [DATA_WIDTH-1:0]   w_data_in_2;
    logic [STRB_WIDTH-1:0]   w_write_en_2;

    // A zero-strobe write touches no bytes, so it cannot collide with a read.
    assign w_collision = s_req.rd_valid & s_req.wr_valid & (|s_req.wr_strb)
                       & (s_req.rd_addr == s_req.wr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_INIT;
            r_cnt           <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_rd_data_valid <= s_req.rd_valid & w_rd_ready;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s_req.init_req) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_busy       = 1'b0;
        w_rd_ready   = 1'b0;
        w_wr_ready   = 1'b0;
        w_addr_2     = s_req.wr_addr;
        w_data_in_2  = s_req.wr_data;
        w_write_en_2 = '0;
        if (reset) begin
            w_busy = 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_busy       = 1'b1;
                    w_addr_2     = r_cnt;
                    w_data_in_2  = '0;
                    w_write_en_2 = '1;
                end
                ST_RUN: begin
                    w_wr_ready = 1'b1;
                    w_rd_ready = ~w_collision;
                    if (s_req.wr_valid) begin
                        w_write_en_2 = s_req.wr_strb;
                    end
                end
                default: begin
                    w_busy = 1'b1;
                end
            endcase
        end
    end

    assign s_req.busy          = w_busy;
    assign s_req.rd_ready      = w_rd_ready;
    assign s_req.wr_ready      = w_wr_ready;
    assign s_req.rd_data_valid = r_rd_data_valid;
    assign s_req.rd_data       = m_ram.ram_data_out_1;

    // Read address bypasses any register so the RAM's own read register
    // provides the single cycle of latency.
    assign m_ram.ram_en         = 1'b1;
    assign m_ram.ram_addr_1     = s_req.rd_addr;
    assign m_ram.ram_write_en_1 = '0;
    assign m_ram.ram_addr_2     = w_addr_2;
    assign m_ram.ram_data_in_2  = w_data_in_2;
    assign m_ram.ram_write_en_2 = w_write_en_2;
endmodule

// File: tb/tb_bram_access_scheduler.sv
// Directed bench for bram_access_scheduler with a byte-writable dual-port
// RAM model (registered read on port 1, write on port 2).
module tb_bram_access_scheduler;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] model [DEPTH];

    always #5 clk = ~clk;

    bram_access_scheduler_if     #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req_if ();
    bram_access_scheduler_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram_if ();

    bram_access_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .s_req (req_if),
        .m_ram (ram_if)
    );

    always @(posedge clk) begin
        ram_if.ram_data_out_1 <= mem[ram_if.ram_addr_1];
        for (int b = 0; b < SW; b++) begin
            if (ram_if.ram_write_en_2[b]) begin
                mem[ram_if.ram_addr_2][b*8 +: 8] <= ram_if.ram_data_in_2[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_if.init_req = 1'b0;
        req_if.rd_valid = 1'b0;
        req_if.rd_addr  = '0;
        req_if.wr_valid = 1'b0;
        req_if.wr_addr  = '0;
        req_if.wr_data  = '0;
        req_if.wr_strb  = '0;
    endtask

    task automatic drv_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_if.wr_valid = 1'b1;
        req_if.wr_addr  = a;
        req_if.wr_data  = d;
        req_if.wr_strb  = s;
    endtask

    task automatic drv_rd(input logic [AW-1:0] a);
        req_if.rd_valid = 1'b1;
        req_if.rd_addr  = a;
    endtask

    // Caller has entered the first sweep window and set its inputs.
    task automatic sweep_check(input string tag, input int pulse_at);
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            req_if.init_req = (i == pulse_at);
            #1;
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, req_if.busy}, 32'd1);
            chk($sformatf("%s_addr%0d", tag, i), {28'd0, ram_if.ram_addr_2}, i);
            chk($sformatf("%s_din%0d", tag, i), ram_if.ram_data_in_2, 32'd0);
            chk($sformatf("%s_we%0d", tag, i), {28'd0, ram_if.ram_write_en_2}, 32'hF);
            chk($sformatf("%s_rrdy%0d", tag, i), {31'd0, req_if.rd_ready}, 32'd0);
            chk($sformatf("%s_wrdy%0d", tag, i), {31'd0, req_if.wr_ready}, 32'd0);
        end
        @(negedge clk);
        req_if.init_req = 1'b0;
        #1;
        chk({tag, "_done"}, {31'd0, req_if.busy}, 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            idle();
            if (i < DEPTH) drv_rd(i[AW-1:0]);
            #1;
            if (i < DEPTH) chk($sformatf("%s_rrdy%0d", tag, i), {31'd0, req_if.rd_ready}, 32'd1);
            if (i > 0) begin
                $display("rd %s addr=%0d data=%08h", tag, i - 1, req_if.rd_data);
                chk($sformatf("%s_rdv%0d", tag, i - 1), {31'd0, req_if.rd_data_valid}, 32'd1);
                chk($sformatf("%s_rd%0d", tag, i - 1), req_if.rd_data, model[i-1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        drv_rd(4'd1);
        drv_wr(4'd1, 32'hFFFF_FFFF, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, req_if.busy}, 32'd1);
        chk("rst_rrdy", {31'd0, req_if.rd_ready}, 32'd0);
        chk("rst_wrdy", {31'd0, req_if.wr_ready}, 32'd0);
        chk("rst_we2", {28'd0, ram_if.ram_write_en_2}, 32'd0);
        chk("rst_rdv", {31'd0, req_if.rd_data_valid}, 32'd0);
        chk("ram_en", {31'd0, ram_if.ram_en}, 32'd1);
        chk("we1", {28'd0, ram_if.ram_write_en_1}, 32'd0);

        // Reset release: full clear, with a held read stalling throughout.
        @(negedge clk);
        reset = 1'b0;
        idle();
        drv_rd(4'd2);
        sweep_check("rel", -1);
        chk("held_rrdy", {31'd0, req_if.rd_ready}, 32'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        read_all("clr");

        // Write then read the same address in the following cycle.
        @(negedge clk); idle(); drv_wr(4'd5, 32'hDEAD_BEEF, 4'hF); #1;
        $display("wr addr=5 data=deadbeef");
        chk("wr5_wrdy", {31'd0, req_if.wr_ready}, 32'd1);
        chk("wr5_we2", {28'd0, ram_if.ram_write_en_2}, 32'hF);
        chk("wr5_addr2", {28'd0, ram_if.ram_addr_2}, 32'd5);
        chk("wr5_din2", ram_if.ram_data_in_2, 32'hDEAD_BEEF);
        @(negedge clk); idle(); drv_rd(4'd5); #1;
        chk("rd5_rrdy", {31'd0, req_if.rd_ready}, 32'd1);
        chk("rd5_addr1", {28'd0, ram_if.ram_addr_1}, 32'd5);
        @(negedge clk); idle(); #1;
        chk("rd5_rdv", {31'd0, req_if.rd_data_valid}, 32'd1);
        chk("rd5_data", req_if.rd_data, 32'hDEAD_BEEF);

        // Same-address collision: write wins, read retries next cycle.
        @(negedge clk); idle(); drv_rd(4'd3); drv_wr(4'd3, 32'h1234_5678, 4'hF); #1;
        chk("col_rrdy", {31'd0, req_if.rd_ready}, 32'd0);
        chk("col_wrdy", {31'd0, req_if.wr_ready}, 32'd1);
        @(negedge clk); req_if.wr_valid = 1'b0; #1;
        chk("col_retry", {31'd0, req_if.rd_ready}, 32'd1);
        chk("col_rdv0", {31'd0, req_if.rd_data_valid}, 32'd0);
        @(negedge clk); idle(); #1;
        chk("col_rdv", {31'd0, req_if.rd_data_valid}, 32'd1);
        chk("col_data", req_if.rd_data, 32'h1234_5678);

        // Byte strobes into a cleared word; a zero-strobe write is no collision.
        @(negedge clk); idle(); drv_wr(4'd9, 32'hAABB_CCDD, 4'b0101); #1;
        chk("strb_we2", {28'd0, ram_if.ram_write_en_2}, 32'h5);
        @(negedge clk); idle(); drv_rd(4'd9); drv_wr(4'd9, 32'hFFFF_FFFF, 4'h0); #1;
        chk("strb0_rrdy", {31'd0, req_if.rd_ready}, 32'd1);
        chk("strb0_we2", {28'd0, ram_if.ram_write_en_2}, 32'd0);
        @(negedge clk); idle(); #1;
        chk("strb_data", req_if.rd_data, 32'h00BB_00DD);

        // Fill every address while reading the previous one each cycle.
        for (int i = 0; i <= DEPTH + 1; i++) begin
            @(negedge clk);
            idle();
            if (i < DEPTH) drv_wr(i[AW-1:0], 32'hA000_0000 | i, 4'hF);
            if (i >= 1 && i <= DEPTH) drv_rd(4'(i - 1));
            #1;
            if (i < DEPTH) chk($sformatf("fill_wrdy%0d", i), {31'd0, req_if.wr_ready}, 32'd1);
            if (i >= 1 && i <= DEPTH) chk($sformatf("fill_rrdy%0d", i), {31'd0, req_if.rd_ready}, 32'd1);
            if (i >= 2) chk($sformatf("fill_rd%0d", i - 2), req_if.rd_data, 32'hA000_0000 | (i - 2));
        end

        // init_req in RUN together with a write; the write is still issued.
        @(negedge clk); idle(); req_if.init_req = 1'b1; drv_wr(4'd2, 32'h55, 4'hF); #1;
        chk("ireq_busy", {31'd0, req_if.busy}, 32'd0);
        chk("ireq_wrdy", {31'd0, req_if.wr_ready}, 32'd1);
        chk("ireq_we2", {28'd0, ram_if.ram_write_en_2}, 32'hF);
        chk("ireq_addr2", {28'd0, ram_if.ram_addr_2}, 32'd2);
        @(negedge clk); idle(); drv_rd(4'd4); drv_wr(4'd6, 32'h66, 4'hF);
        sweep_check("ini", 5);
        chk("ini_rrdy", {31'd0, req_if.rd_ready}, 32'd1);
        chk("ini_wrdy", {31'd0, req_if.wr_ready}, 32'd1);
        chk("ini_addr2", {28'd0, ram_if.ram_addr_2}, 32'd6);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model[6] = 32'h66;
        read_all("ini");

        // Reset while the sweep is at address 7 restarts it from 0.
        @(negedge clk); idle(); req_if.init_req = 1'b1; #1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            idle();
            drv_rd(4'd1);
            if (i == 7) reset = 1'b1;
            #1;
            if (i < 7) chk($sformatf("mid_addr%0d", i), {28'd0, ram_if.ram_addr_2}, i);
            chk($sformatf("mid_busy%0d", i), {31'd0, req_if.busy}, 32'd1);
        end
        chk("mid_rst_we2", {28'd0, ram_if.ram_write_en_2}, 32'd0);
        chk("mid_rst_rrdy", {31'd0, req_if.rd_ready}, 32'd0);
        @(negedge clk); #1;
        chk("mid_rst_busy", {31'd0, req_if.busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        idle();
        sweep_check("rst2", -1);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        read_all("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
